// File: rtl/bf16_mac_seq_if.sv
// Port bundle for the bf16 dot-product sequencer.
// Signal names are given from the sequencer's point of view.
// The "slave" modport is the sequencer's side. The "master" modport is
// the environment's side, which covers both the operand front end and
// the combinational FPU.
interface bf16_mac_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MODE_WIDTH = 2,
  parameter int CNT_WIDTH  = 8
);

  // Operand stream
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  last_i;

  // Result stream
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [DATA_WIDTH-1:0] res_o;
  logic                  ovf_o;
  logic [CNT_WIDTH-1:0]  cnt_o;

  // FPU port set (the FPU answers combinationally in the same cycle)
  logic [MODE_WIDTH-1:0] fpu_op_o;
  logic [DATA_WIDTH-1:0] fpu_in1_o;
  logic [DATA_WIDTH-1:0] fpu_in2_o;
  logic [DATA_WIDTH-1:0] fpu_out_i;
  logic                  fpu_ovf_i;

  modport slave (
    input  in_valid_i, a_i, b_i, last_i, res_ready_i, fpu_out_i, fpu_ovf_i,
    output in_ready_o, res_valid_o, res_o, ovf_o, cnt_o,
           fpu_op_o, fpu_in1_o, fpu_in2_o
  );

  modport master (
    output in_valid_i, a_i, b_i, last_i, res_ready_i, fpu_out_i, fpu_ovf_i,
    input  in_ready_o, res_valid_o, res_o, ovf_o, cnt_o,
           fpu_op_o, fpu_in1_o, fpu_in2_o
  );

endinterface

// File: rtl/bf16_mac_seq.sv
// bf16 dot-product sequencer.
// For each accepted operand pair it drives one MUL and then one ADD
// onto a shared combinational FPU, and accumulates the result into a
// running sum. When the pair tagged "last" has been added, it presents
// the sum, a sticky overflow flag and a saturating pair count, and holds
// them until the consumer accepts the result.
module bf16_mac_seq #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    MODE_WIDTH = 2,
  parameter logic [MODE_WIDTH-1:0] OP_ADD     = 2'd0,
  parameter logic [MODE_WIDTH-1:0] OP_MUL     = 2'd1,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bf16_mac_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Captured operand pair
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic                  last_reg;

  // Accumulation state for the current job
  logic [DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0] acc;
  logic                  ovf;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  job_open;

  // Combinational outputs produced by the FSM
  logic                  in_ready;
  logic                  res_valid;
  logic [MODE_WIDTH-1:0] fpu_op;
  logic [DATA_WIDTH-1:0] fpu_in1;
  logic [DATA_WIDTH-1:0] fpu_in2;

  logic accept;

  // A pair is taken only while the sequencer is idle and ready
  assign accept = bus.in_valid_i && in_ready;

  // State register; a synchronous reset abandons any job in flight
  always_ff @(posedge clk_i) begin
    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples its inputs from before the edge.
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the per-state FPU, handshake and result-valid drive
  always_comb begin
    // NOTE: every output is given a default first, so that no path
    // through the case statement leaves a signal unassigned and infers
    // a latch.
    next_state = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    fpu_op     = OP_ADD;
    fpu_in1    = '0;
    fpu_in2    = '0;

    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) begin
          next_state = S_MUL;
        end
      end

      S_MUL: begin
        fpu_op     = OP_MUL;
        fpu_in1    = a_reg;
        fpu_in2    = b_reg;
        next_state = S_ADD;
      end

      S_ADD: begin
        fpu_op     = OP_ADD;
        fpu_in1    = acc;
        fpu_in2    = prod;
        next_state = last_reg ? S_DONE : S_IDLE;
      end

      S_DONE: begin
        res_valid = 1'b1;
        if (bus.res_ready_i) begin
          next_state = S_IDLE;
        end
      end

      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture, product/sum registration, sticky overflow and counter
  always_ff @(posedge clk_i) begin
    // NOTE: these are plain flops rather than a memory array, so every
    // one of them can be given a defined value on reset at no cost.
    if (rst_i) begin
      a_reg    <= '0;
      b_reg    <= '0;
      last_reg <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      job_open <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            a_reg    <= bus.a_i;
            b_reg    <= bus.b_i;
            last_reg <= bus.last_i;
            // The first pair of a job starts a fresh sum. The previous
            // job's result stays visible until then.
            if (!job_open) begin
              acc      <= '0;
              ovf      <= 1'b0;
              cnt      <= '0;
              job_open <= 1'b1;
            end
          end
        end

        S_MUL: begin
          prod <= bus.fpu_out_i;
          ovf  <= ovf | bus.fpu_ovf_i;
        end

        S_ADD: begin
          acc <= bus.fpu_out_i;
          ovf <= ovf | bus.fpu_ovf_i;
          // The count saturates so that very long jobs never wrap to a
          // small value.
          if (cnt != {CNT_WIDTH{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (bus.res_ready_i) begin
            job_open <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

  // Result fields mirror the internal registers. They are qualified by
  // res_valid_o.
  assign bus.in_ready_o  = in_ready;
  assign bus.res_valid_o = res_valid;
  assign bus.res_o       = acc;
  assign bus.ovf_o       = ovf;
  assign bus.cnt_o       = cnt;
  assign bus.fpu_op_o    = fpu_op;
  assign bus.fpu_in1_o   = fpu_in1;
  assign bus.fpu_in2_o   = fpu_in2;

endmodule

// File: doc/bf16_mac_seq.md
Name: bf16_mac_seq

Overview:
Initiator for the combinational bfloat16 FPU port set (op, in1, in2 -> out, overflow). It accepts a stream of operand pairs over a valid/ready handshake and issues one MUL then one ADD per pair to the FPU. The result accumulates into a running sum, which is returned as a single bf16 dot-product result with a sticky overflow flag and a pair count. It sits between a data-movement front end and the FPU instance, and owns all sequencing the FPU itself lacks.

Parameters:
DATA_WIDTH, 16, bf16 word width (1 sign, 8 exp, 7 frac)
MODE_WIDTH, 2, width of FPU op select
OP_ADD, 2'd0, op code driven for FPU addition
OP_MUL, 2'd1, op code driven for FPU multiplication
CNT_WIDTH, 8, width of pair counter

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
in_valid_i  input  1  operand pair valid
in_ready_o  output  1  sequencer can accept a pair
a_i  input  DATA_WIDTH  operand A (bf16)
b_i  input  DATA_WIDTH  operand B (bf16)
last_i  input  1  pair is the last of the job
res_valid_o  output  1  result valid
res_ready_i  input  1  result consumer ready
res_o  output  DATA_WIDTH  accumulated sum (bf16)
ovf_o  output  1  sticky overflow over the job
cnt_o  output  CNT_WIDTH  pairs accumulated in the job
fpu_op_o  output  MODE_WIDTH  op select to FPU
fpu_in1_o  output  DATA_WIDTH  FPU operand 1
fpu_in2_o  output  DATA_WIDTH  FPU operand 2
fpu_out_i  input  DATA_WIDTH  FPU result (combinational, same cycle)
fpu_ovf_i  input  1  FPU overflow (combinational, same cycle)

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high.
- States: IDLE, MUL, ADD, DONE. On reset: state=IDLE, acc=0x0000, prod=0, a/b/last regs=0, ovf=0, cnt=0.
- Reset output values: in_ready_o=1, res_valid_o=0, res_o=0x0000, ovf_o=0, cnt_o=0, fpu_op_o=OP_ADD, fpu_in1_o=0, fpu_in2_o=0.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o, capture a_i, b_i, last_i and go to MUL.
  - If this is the first pair of a job (job_open=0), also clear acc to 0x0000, ovf to 0 and cnt to 0, then set job_open=1.
- MUL (1 cycle):
  - Drive fpu_op_o=OP_MUL, fpu_in1_o=a_reg, fpu_in2_o=b_reg.
  - Register prod<=fpu_out_i and ovf<=ovf|fpu_ovf_i. Go to ADD.
- ADD (1 cycle):
  - Drive fpu_op_o=OP_ADD, fpu_in1_o=acc, fpu_in2_o=prod.
  - Register acc<=fpu_out_i, ovf<=ovf|fpu_ovf_i, and cnt<=cnt+1, saturating at all-ones.
  - If last_reg, go to DONE; otherwise go to IDLE.
- DONE:
  - res_valid_o=1; res_o=acc, ovf_o=ovf and cnt_o=cnt held stable.
  - in_ready_o=0.
  - On res_ready_i, go to IDLE and clear job_open.
- res_o, ovf_o and cnt_o always reflect the internal registers. They are only meaningful while res_valid_o=1.
- In IDLE and DONE: fpu_op_o=OP_ADD, fpu_in1_o=0, fpu_in2_o=0. The FPU output is ignored in these states.
- in_ready_o is 0 in MUL, ADD and DONE.
- Latency and throughput:
  - One pair per 3 cycles (accept, MUL, ADD).
  - res_valid_o rises 2 cycles after the accept of the last pair.
- Back-to-back: a new pair may be accepted in the IDLE cycle immediately after ADD.
- in_valid_i is not required to stay high; a_i, b_i and last_i are sampled only on the accept edge.
- Result backpressure: DONE holds indefinitely; outputs stay stable until the handshake completes.
- Reset mid-operation: from any state, the next cycle is IDLE with all reset values. The in-flight job is discarded and no result is emitted.
- The NaN/Inf/overflow result encoding is whatever the FPU returns; this block does no special-case handling.

Test Plan:
- Job (0x3F80,0x4000),(0x4040,0x3F00,last), i.e. 1*2 + 3*0.5 -> res_valid_o 2 cycles after the second accept. Required: res_o=0x4060 (3.5), cnt_o=2, ovf_o=0. FPU op sequence must be MUL,ADD,MUL,ADD.
- Single-pair job (0x4000,0x4040,last) -> res_o=0x40C0 (6.0), cnt_o=1. in_ready_o must be low for exactly 3 cycles, from MUL through the DONE handshake cycle.
- Overflow: pair (0x7F00,0x7F00,last) -> ovf_o=1. Next job (0x3F80,0x3F80,last) -> res_o=0x3F80, ovf_o=0 (sticky cleared per job).
- Backpressure: hold res_ready_i=0 for 5 cycles in DONE with in_valid_i=1. Required: res_valid_o=1 and res_o/cnt_o stable, in_ready_o=0, no pair accepted. Raising res_ready_i gives IDLE next cycle.
- Reset mid-job: assert rst_i for 1 cycle while in ADD of pair 2 of 3. Required next cycle: in_ready_o=1, res_valid_o=0, cnt_o=0, fpu_in1_o=fpu_in2_o=0. A fresh 1-pair job (0x3F80,0x3F80,last) then yields res_o=0x3F80.
- Counter saturation (CNT_WIDTH=8): 300-pair job of (0x0000,0x0000) -> cnt_o=255, res_o=0x0000.
